zigbee_pad_host: RTL and testbench
==================================

// Module: zigbee_pad_host
// PURPOSE
//  Host-side (tester/FPGA) end of the zigbee pad-mux link. Drives the chip's 22 input pads and samples its 18 output pads.
//  Follows the chip-driven mode select. Moves 16-bit words both ways using two independent 4-phase req/ack handshakes.
//  All pad inputs are asynchronous to clk_i and pass through synchronisers.
// PARAMETERS
//  SYNC_STAGES  2     flops per synchroniser on sel/ack/vld pad inputs (>=2)
//  TIMEOUT_CYC  1024  max cycles waiting on any pad handshake edge before abort
// PORTS
//  clk_i          in   1   host clock; all logic on rising edge
//  resetn_i       in   1   asynchronous, active-low reset
//  pad_sel_i      in   2   chip mode: 00 idle, 01 host->chip, 10 chip->host, 11 reserved (treated as 00)
//  pad_out_i      in   18  chip output pads {ack[17], vld[16], data[15:0]}
//  pad_in_o       out  22  chip input pads {req[21], hack[20], cmd[19:16], data[15:0]}, registered
//  tx_valid_i     in   1   host word to send
//  tx_ready_o     out  1   tx accepted this cycle when tx_valid_i&tx_ready_o
//  tx_cmd_i       in   4   command nibble
//  tx_data_i      in   16  data word
//  rx_valid_o     out  1   received word available
//  rx_ready_i     in   1   downstream takes word when rx_valid_o&rx_ready_i
//  rx_data_o      out  16  received word
//  err_timeout_o  out  1   one-cycle pulse on any handshake timeout
//  tx_count_o     out  16  completed tx words, wraps 0xFFFF->0
//  rx_count_o     out  16  completed rx words, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: pad_in_o=0, tx_ready_o=0, rx_valid_o=0, rx_data_o=0, err_timeout_o=0, counts=0, both FSMs idle.
//  Synchronisers: sel_s, ack_s, vld_s = pad bits delayed by SYNC_STAGES. Data pads are sampled raw; the chip holds them stable while vld=1.
//  TX FSM (T_IDLE, T_REQ, T_REL):
//   T_IDLE: tx_ready_o=1 iff sel_s==01. On accept, latch cmd/data into pad_in_o[19:0] and set req=1 the next cycle (1-cycle latency). Go to T_REQ.
//   T_REQ: hold req/cmd/data; on ack_s==1 -> req=0 next cycle, go to T_REL.
//   T_REL: on ack_s==0 -> tx_count_o+1, go to T_IDLE. tx_ready_o may rise in the same cycle.
//   Once started, a transfer completes even if sel_s changes to 10.
//  RX FSM (R_IDLE, R_HOLD, R_ACK):
//   R_IDLE: if sel_s==10 and vld_s==1 -> rx_data_o<=pad_out_i[15:0], rx_valid_o=1 next cycle, go to R_HOLD.
//   R_HOLD: wait rx_ready_i. This is backpressure: hack stays 0, so the chip holds its word. On handshake -> rx_valid_o=0, hack=1, go to R_ACK.
//   R_ACK: on vld_s==0 -> hack=0, rx_count_o+1, go to R_IDLE.
//  TX and RX FSMs run concurrently and independently. The req and hack bits never interfere.
//  Timeout: a per-FSM counter is cleared on state entry and runs in T_REQ, T_REL and R_ACK.
//   On reaching TIMEOUT_CYC-1 the FSM goes idle, drops req (or hack), and err_timeout_o pulses for 1 cycle. The count is not incremented.
//   R_HOLD never times out (host-side stall is legal).
//   Simultaneous TX and RX timeouts produce a single pulse.
//  Abort: sel_s==00 or 11 forces both FSMs idle next cycle.
//   Effects: req=0, hack=0, tx_ready_o=0, rx_valid_o=0 (held rx word discarded). Counts are kept and err_timeout_o is not pulsed.
//  Reset asserted mid-transfer: immediate async clear of everything. The chip sees req/hack fall without completion.
//  Counter width: 16-bit modulo. The timeout counter is $clog2(TIMEOUT_CYC) bits and saturates.
// TESTING
//  1. Reset with pads toggling -> pad_in_o==0, rx_valid_o==0, tx_ready_o==0 until sel=01 is synced (SYNC_STAGES+1 cycles).
//  2. sel=01; send cmd=0x5, data=0xA5C3; chip model acks after 7 cycles -> pad_in_o=0x25A5C3 until ack_s, then req=0; after ack drop tx_count_o==1.
//  3. sel=10; chip presents vld=1, data=0x1234; hold rx_ready_i=0 for 20 cycles -> rx_valid_o=1, rx_data_o=0x1234, hack=0 throughout; then ready=1 -> hack=1; vld drop -> hack=0, rx_count_o==1.
//  4. TIMEOUT_CYC=16; chip never acks tx -> req drops and err_timeout_o pulses exactly 16 cycles after req rose; tx_count_o unchanged; next tx accepted.
//  5. Mid-R_HOLD, sel goes 00 -> within SYNC_STAGES+1 cycles rx_valid_o=0, hack=0, tx_ready_o=0; no timeout pulse.
//  6. Preload tx_count_o to 0xFFFF (65535 transfers, or a force) -> next transfer gives 0x0000; concurrent tx/rx at sel=01->10 switch: tx completes, rx then proceeds.

Source files
------------

// File: rtl/zigbee_pad_host.sv
// Host-side end of the zigbee pad-mux link. It drives the chip input pads and samples the
// chip output pads. It moves 16-bit words to the chip (TX) and from the chip (RX), each
// over its own 4-phase req/ack handshake. The chip-driven mode select chooses the direction.
module zigbee_pad_host #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_i,
  input  logic        resetn_i,
  input  logic [1:0]  pad_sel_i,
  input  logic [17:0] pad_out_i,
  output logic [21:0] pad_in_o,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [3:0]  tx_cmd_i,
  input  logic [15:0] tx_data_i,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [15:0] rx_data_o,
  output logic        err_timeout_o,
  output logic [15:0] tx_count_o,
  output logic [15:0] rx_count_o
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TLast = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {TIdle, TReq, TRel} tx_state_e;
  typedef enum logic [1:0] {RIdle, RHold, RAck} rx_state_e;

  tx_state_e       tx_state_q;
  rx_state_e       rx_state_q;
  logic [TW-1:0]   tx_timer_q, rx_timer_q;
  logic            req_q, hack_q, tx_ready_q, rx_valid_q, err_q;
  logic [19:0]     tx_word_q;
  logic [15:0]     rx_data_q, tx_count_q, rx_count_q;

  // Each stage holds {sel[1:0], ack, vld}.
  logic [3:0]      sync_q [SYNC_STAGES];
  logic [1:0]      sel_s;
  logic            ack_s, vld_s, abort, tx_to, rx_to;

  function automatic logic [TW-1:0] inc_sat(input logic [TW-1:0] v);
    return (v == TLast) ? v : v + TW'(1);
  endfunction

  // Synchronise the asynchronous control pads; the data pads are sampled raw.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= {pad_sel_i, pad_out_i[17], pad_out_i[16]};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Decode the synchronised controls, the abort condition and the per-FSM timeout hits.
  always_comb begin
    sel_s = sync_q[SYNC_STAGES-1][3:2];
    ack_s = sync_q[SYNC_STAGES-1][1];
    vld_s = sync_q[SYNC_STAGES-1][0];
    // A reserved select value counts as idle and aborts both directions.
    abort = (sel_s == 2'b00) || (sel_s == 2'b11);
    tx_to = 1'b0;
    rx_to = 1'b0;
    if (!abort && tx_timer_q == TLast) begin
      tx_to = (tx_state_q == TReq && !ack_s) || (tx_state_q == TRel && ack_s);
    end
    if (!abort && rx_timer_q == TLast) begin
      rx_to = (rx_state_q == RAck) && vld_s;
    end
  end

  // TX FSM: latch the host word onto the pads, raise req, and wait for the chip ack to cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      tx_state_q <= TIdle;
      tx_timer_q <= '0;
      req_q      <= 1'b0;
      tx_word_q  <= '0;
      tx_ready_q <= 1'b0;
      tx_count_q <= '0;
    end else begin
      unique case (tx_state_q)
        TIdle: begin
          if (tx_valid_i && tx_ready_q) begin
            tx_word_q  <= {tx_cmd_i, tx_data_i};
            req_q      <= 1'b1;
            tx_ready_q <= 1'b0;
            tx_timer_q <= '0;
            tx_state_q <= TReq;
          end else begin
            tx_ready_q <= (sel_s == 2'b01);
          end
        end
        TReq: begin
          if (abort || tx_to) begin
            req_q      <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_state_q <= TIdle;
          end else if (ack_s) begin
            req_q      <= 1'b0;
            tx_timer_q <= '0;
            tx_state_q <= TRel;
          end else begin
            tx_timer_q <= inc_sat(tx_timer_q);
          end
        end
        TRel: begin
          if (abort || tx_to) begin
            tx_ready_q <= 1'b0;
            tx_state_q <= TIdle;
          end else if (!ack_s) begin
            tx_count_q <= tx_count_q + 16'd1;
            tx_ready_q <= (sel_s == 2'b01);
            tx_state_q <= TIdle;
          end else begin
            tx_timer_q <= inc_sat(tx_timer_q);
          end
        end
        default: begin
          req_q      <= 1'b0;
          tx_ready_q <= 1'b0;
          tx_state_q <= TIdle;
        end
      endcase
    end
  end

  // RX FSM: capture the chip word, hold it under backpressure, then acknowledge with hack.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      rx_state_q <= RIdle;
      rx_timer_q <= '0;
      hack_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      rx_count_q <= '0;
    end else begin
      unique case (rx_state_q)
        RIdle: begin
          if (sel_s == 2'b10 && vld_s) begin
            rx_data_q  <= pad_out_i[15:0];
            rx_valid_q <= 1'b1;
            rx_state_q <= RHold;
          end
        end
        RHold: begin
          // No timeout here: a stalled host is legal and the chip just keeps its word.
          if (abort) begin
            rx_valid_q <= 1'b0;
            rx_state_q <= RIdle;
          end else if (rx_ready_i) begin
            rx_valid_q <= 1'b0;
            hack_q     <= 1'b1;
            rx_timer_q <= '0;
            rx_state_q <= RAck;
          end
        end
        RAck: begin
          if (abort || rx_to) begin
            hack_q     <= 1'b0;
            rx_state_q <= RIdle;
          end else if (!vld_s) begin
            hack_q     <= 1'b0;
            rx_count_q <= rx_count_q + 16'd1;
            rx_state_q <= RIdle;
          end else begin
            rx_timer_q <= inc_sat(rx_timer_q);
          end
        end
        default: begin
          hack_q     <= 1'b0;
          rx_valid_q <= 1'b0;
          rx_state_q <= RIdle;
        end
      endcase
    end
  end

  // A TX timeout and an RX timeout in the same cycle give one merged pulse.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) err_q <= 1'b0;
    else           err_q <= tx_to | rx_to;
  end

  assign pad_in_o      = {req_q, hack_q, tx_word_q};
  assign tx_ready_o    = tx_ready_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_data_o     = rx_data_q;
  assign err_timeout_o = err_q;
  assign tx_count_o    = tx_count_q;
  assign rx_count_o    = rx_count_q;

endmodule

// File: tb/tb_zigbee_pad_host.sv
// Directed bench for zigbee_pad_host. It uses SYNC_STAGES=2 and TIMEOUT_CYC=16.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_zigbee_pad_host;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  pad_sel = 2'b00;
  logic        ack = 1'b0, vld = 1'b0;
  logic [15:0] cdata = '0;
  logic [21:0] pad_in;
  logic        tx_valid = 1'b0, tx_ready;
  logic [3:0]  tx_cmd = '0;
  logic [15:0] tx_data = '0;
  logic        rx_valid, rx_ready = 1'b0;
  logic [15:0] rx_data;
  logic        err;
  logic [15:0] tx_count, rx_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  zigbee_pad_host #(.SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .resetn_i(resetn), .pad_sel_i(pad_sel), .pad_out_i({ack, vld, cdata}),
    .pad_in_o(pad_in), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready), .tx_cmd_i(tx_cmd),
    .tx_data_i(tx_data), .rx_valid_o(rx_valid), .rx_ready_i(rx_ready), .rx_data_o(rx_data),
    .err_timeout_o(err), .tx_count_o(tx_count), .rx_count_o(rx_count)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      pad_sel = i[1] ? 2'b01 : 2'b10;
      ack = i[0];
      vld = ~i[0];
      cdata = 16'($urandom);
      tick(1);
      total++;
      if ({pad_in, tx_ready, rx_valid, err, tx_count, rx_count, rx_data} !== '0) begin
        bad++;
        $display("FAIL reset_state: pad_in=%h rdy=%b vld=%b err=%b txc=%h rxc=%h want all 0",
                 pad_in, tx_ready, rx_valid, err, tx_count, rx_count);
      end
    end
    pad_sel = 2'b01; ack = 1'b0; vld = 1'b0;
    resetn = 1'b1;
    tick(2);
    total++;
    if ({tx_ready, rx_valid} !== 2'b00) begin
      bad++; $display("FAIL ready_before_sync: rdy=%b vld=%b want 0 0", tx_ready, rx_valid);
    end
    tick(1);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL ready_after_sync: got %b want 1", tx_ready);
    end
  endtask

  task automatic test_tx();
    tx_valid = 1'b1; tx_cmd = 4'h5; tx_data = 16'hA5C3;
    tick(1);
    tx_valid = 1'b0;
    total++;
    if (pad_in !== 22'h25A5C3 || tx_ready !== 1'b0) begin
      bad++; $display("FAIL tx_req_rise: pad_in=%h rdy=%b want 25a5c3 0", pad_in, tx_ready);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1);
      total++;
      if (pad_in !== 22'h25A5C3) begin
        bad++; $display("FAIL tx_req_hold: pad_in=%h want 25a5c3", pad_in);
      end
    end
    ack = 1'b1;
    tick(2);
    total++;
    if (pad_in !== 22'h25A5C3) begin
      bad++; $display("FAIL tx_req_before_ack_sync: pad_in=%h want 25a5c3", pad_in);
    end
    tick(1);
    total++;
    if (pad_in !== 22'h05A5C3) begin
      bad++; $display("FAIL tx_req_drop: pad_in=%h want 05a5c3", pad_in);
    end
    ack = 1'b0;
    tick(2);
    total++;
    if (tx_count !== 16'd0) begin
      bad++; $display("FAIL tx_count_early: got %h want 0", tx_count);
    end
    tick(1);
    total++;
    if (tx_count !== 16'd1 || tx_ready !== 1'b1) begin
      bad++; $display("FAIL tx_done: count=%h rdy=%b want 1 1", tx_count, tx_ready);
    end
  endtask

  task automatic test_rx_backpressure();
    pad_sel = 2'b10; vld = 1'b1; cdata = 16'h1234;
    tick(2);
    total++;
    if (rx_valid !== 1'b0) begin
      bad++; $display("FAIL rx_valid_early: got %b want 0", rx_valid);
    end
    tick(1);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 16'h1234 || tx_ready !== 1'b0) begin
      bad++; $display("FAIL rx_capture: vld=%b data=%h rdy=%b want 1 1234 0",
                      rx_valid, rx_data, tx_ready);
    end
    for (int i = 0; i < 20; i++) begin
      tick(1);
      total++;
      if ({rx_valid, pad_in[20], err} !== 3'b100) begin
        bad++; $display("FAIL rx_hold: vld=%b hack=%b err=%b want 1 0 0",
                        rx_valid, pad_in[20], err);
      end
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    total++;
    if (pad_in[20] !== 1'b1 || rx_valid !== 1'b0) begin
      bad++; $display("FAIL rx_hack_rise: hack=%b vld=%b want 1 0", pad_in[20], rx_valid);
    end
    vld = 1'b0;
    tick(2);
    total++;
    if (pad_in[20] !== 1'b1) begin
      bad++; $display("FAIL rx_hack_hold: got %b want 1", pad_in[20]);
    end
    tick(1);
    total++;
    if (pad_in[20] !== 1'b0 || rx_count !== 16'd1) begin
      bad++; $display("FAIL rx_done: hack=%b count=%h want 0 1", pad_in[20], rx_count);
    end
  endtask

  task automatic test_timeout();
    pad_sel = 2'b01;
    tick(3);
    total++;
    if (tx_ready !== 1'b1) begin
      bad++; $display("FAIL to_ready: got %b want 1", tx_ready);
    end
    tx_valid = 1'b1; tx_cmd = 4'hC; tx_data = 16'hBEEF;
    tick(1);
    tx_valid = 1'b0;
    total++;
    if ({pad_in[21], err} !== 2'b10) begin
      bad++; $display("FAIL to_req_rise: req=%b err=%b want 1 0", pad_in[21], err);
    end
    for (int k = 1; k < 16; k++) begin
      tick(1);
      total++;
      if ({pad_in[21], err} !== 2'b10) begin
        bad++; $display("FAIL to_wait cyc %0d: req=%b err=%b want 1 0", k, pad_in[21], err);
      end
    end
    tick(1);
    total++;
    if ({pad_in[21], err} !== 2'b01) begin
      bad++; $display("FAIL to_fire: req=%b err=%b want 0 1", pad_in[21], err);
    end
    tick(1);
    total++;
    if (err !== 1'b0 || tx_count !== 16'd1 || tx_ready !== 1'b1) begin
      bad++; $display("FAIL to_after: err=%b count=%h rdy=%b want 0 1 1", err, tx_count, tx_ready);
    end
    tx_valid = 1'b1; tx_cmd = 4'h3; tx_data = 16'h0F0F;
    tick(1);
    tx_valid = 1'b0;
    total++;
    if (pad_in !== 22'h230F0F) begin
      bad++; $display("FAIL to_next_tx: pad_in=%h want 230f0f", pad_in);
    end
    ack = 1'b1;
    tick(3);
    ack = 1'b0;
    tick(3);
    total++;
    if (tx_count !== 16'd2 || pad_in[21] !== 1'b0) begin
      bad++; $display("FAIL to_next_done: count=%h req=%b want 2 0", tx_count, pad_in[21]);
    end
  endtask

  task automatic test_abort();
    pad_sel = 2'b10; vld = 1'b1; cdata = 16'hBEEF;
    tick(3);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 16'hBEEF) begin
      bad++; $display("FAIL ab_capture: vld=%b data=%h want 1 beef", rx_valid, rx_data);
    end
    tick(2);
    pad_sel = 2'b00;
    tick(2);
    total++;
    if (rx_valid !== 1'b1) begin
      bad++; $display("FAIL ab_before_sync: vld=%b want 1", rx_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      total++;
      if ({rx_valid, pad_in[20], tx_ready, err} !== 4'b0000) begin
        bad++; $display("FAIL ab_idle: vld=%b hack=%b rdy=%b err=%b want 0 0 0 0",
                        rx_valid, pad_in[20], tx_ready, err);
      end
    end
    total++;
    if (rx_count !== 16'd1 || tx_count !== 16'd2) begin
      bad++; $display("FAIL ab_counts: rx=%h tx=%h want 1 2", rx_count, tx_count);
    end
    vld = 1'b0;
  endtask

  task automatic test_wrap_concurrent();
    pad_sel = 2'b01;
    tick(3);
    force dut.tx_count_q = 16'hFFFF;
    tick(1);
    release dut.tx_count_q;
    tick(1);
    total++;
    if (tx_count !== 16'hFFFF || tx_ready !== 1'b1) begin
      bad++; $display("FAIL wr_preload: count=%h rdy=%b want ffff 1", tx_count, tx_ready);
    end
    tx_valid = 1'b1; tx_cmd = 4'hA; tx_data = 16'h0001;
    tick(1);
    tx_valid = 1'b0;
    total++;
    if (pad_in !== 22'h2A0001) begin
      bad++; $display("FAIL wr_req: pad_in=%h want 2a0001", pad_in);
    end
    pad_sel = 2'b10; vld = 1'b1; cdata = 16'h5A5A;
    tick(3);
    total++;
    if (rx_valid !== 1'b1 || rx_data !== 16'h5A5A || pad_in[21] !== 1'b1) begin
      bad++; $display("FAIL wr_concurrent: vld=%b data=%h req=%b want 1 5a5a 1",
                      rx_valid, rx_data, pad_in[21]);
    end
    ack = 1'b1;
    tick(3);
    total++;
    if (pad_in[21] !== 1'b0 || pad_in[20] !== 1'b0) begin
      bad++; $display("FAIL wr_req_drop: req=%b hack=%b want 0 0", pad_in[21], pad_in[20]);
    end
    ack = 1'b0;
    tick(3);
    total++;
    if (tx_count !== 16'h0000) begin
      bad++; $display("FAIL wr_wrap: count=%h want 0000", tx_count);
    end
    rx_ready = 1'b1;
    tick(1);
    rx_ready = 1'b0;
    total++;
    if (pad_in[20] !== 1'b1 || pad_in[21] !== 1'b0) begin
      bad++; $display("FAIL wr_hack: hack=%b req=%b want 1 0", pad_in[20], pad_in[21]);
    end
    vld = 1'b0;
    tick(3);
    total++;
    if (pad_in[20] !== 1'b0 || rx_count !== 16'd2) begin
      bad++; $display("FAIL wr_rx_done: hack=%b count=%h want 0 2", pad_in[20], rx_count);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx_backpressure();
    test_timeout();
    test_abort();
    test_wrap_concurrent();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
